simd_result_loader: RTL and testbench
=====================================

// Module: simd_result_loader
// PURPOSE
//  Sequences per-lane streaming-op results into the SIMD register file. Captures each exec lane's result,
//  waits until every lane in the configured mask is valid, then writes the results one per accepted
//  handshake into the SIMD regfile write port. Sits between the stOp result path and the SIMD core.
// PARAMETERS
//  NUM_LANES    32  number of exec lanes (PE_NUM_OF_EXEC_LANES)
//  LANE_WIDTH   32  result width per lane (PE_EXEC_LANE_WIDTH)
//  REG_ADDR_W   5   SIMD regfile register index width
// PORTS
//  clk                 in   1                     clock; all state updates on posedge
//  reset_poweron       in   1                     synchronous, active-high reset
//  lane_result_valid   in   NUM_LANES             per-lane 1-cycle result strobe
//  lane_result         in   NUM_LANES*LANE_WIDTH  per-lane result; lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//  cfg_valid           in   1                     load request present
//  cfg_ready           out  1                     load request accepted (high only in IDLE)
//  cfg_dest_reg        in   REG_ADDR_W            destination regfile register
//  cfg_lane_mask       in   NUM_LANES             lanes participating in this load
//  rf_wr_valid         out  1                     regfile write request
//  rf_wr_ready         in   1                     regfile accepts write (arbitration won)
//  rf_wr_lane          out  log2(NUM_LANES)       lane being written
//  rf_wr_addr          out  REG_ADDR_W            = latched cfg_dest_reg
//  rf_wr_data          out  LANE_WIDTH            captured result of rf_wr_lane
//  load_done           out  1                     1-cycle pulse, load complete
//  busy                out  1                     state != IDLE
//  overrun_err         out  1                     sticky: result arrived for a lane already holding one
// BEHAVIOUR
//  Reset: all capture regs/valid flags 0, state IDLE, cfg_ready=1, rf_wr_valid=0, load_done=0, busy=0,
//   overrun_err=0, rf_wr_lane/addr/data=0. Reset mid-operation aborts with no load_done.
//  Capture (every state): lane_result_valid[i] -> data_q[i]<=lane_result[i], vld_q[i]<=1 next edge.
//   Strobe while vld_q[i]=1: data overwritten, overrun_err<=1 (cleared only by reset).
//  FSM:
//   IDLE:    cfg_ready=1; on cfg_valid latch mask/dest_reg -> COLLECT.
//   COLLECT: when (vld_q & mask)==mask -> WRITE with lane ptr = lowest set mask bit.
//            mask==0 -> DONE directly.
//   WRITE:   rf_wr_valid=1, lane/addr/data held stable until rf_wr_ready. On valid&&ready: if no
//            higher mask bit remains -> DONE, else ptr = next higher set bit (same cycle, no bubble).
//   DONE:    load_done=1 for one cycle; clear vld_q for masked lanes -> IDLE.
//  Simultaneous: strobe on a masked lane in DONE cycle -> set wins (vld_q stays 1, new data kept, no
//   overrun flagged). Strobes on unmasked lanes captured and retained for later loads.
//  Latency: last masked strobe at edge N -> vld_q at N+1 -> rf_wr_valid at N+2 (COLLECT->WRITE).
//   With rf_wr_ready held 1: k-lane mask completes in k WRITE cycles, load_done cycle after last write.
//  rf_wr_data sampled from data_q at the moment of write; overwrite during WRITE of an unwritten lane
//   delivers the newer value.
// TESTING
//  1 mask=0xFFFFFFFF, all lanes strobe lane i=i+100, ready=1 -> 32 writes lanes 0..31 data 100..131,
//    addr=dest, load_done 1 cycle after last write, vld_q masked bits clear.
//  2 mask=0x00000005, ready toggles 0/1 -> writes only lanes 0 then 2; outputs stable while ready=0.
//  3 mask=0 -> cfg accepted, load_done 2 cycles later, zero writes.
//  4 lane 3 strobed twice (0xA then 0xB) before load, mask=0x8 -> overrun_err=1, write data 0xB.
//  5 reset asserted during WRITE after 4 of 8 writes -> next cycle IDLE, rf_wr_valid=0, no load_done,
//    all vld_q=0, overrun_err=0.
//  6 lane 5 strobed in DONE cycle of mask=0x20 load -> vld_q[5]=1 after; next load mask=0x20 writes new value.

Source files
------------

// File: rtl/simd_result_loader.sv
// Captures per-lane streaming-op results and, once every lane in the requested mask holds a result,
// writes them lowest lane first into the SIMD regfile, one per accepted handshake.
module simd_result_loader #(
  parameter int  NUM_LANES  = 32,
  parameter int  LANE_WIDTH = 32,
  parameter int  REG_ADDR_W = 5,
  localparam int IDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic [NUM_LANES-1:0]            lane_result_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_result,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [REG_ADDR_W-1:0]           cfg_dest_reg,
  input  logic [NUM_LANES-1:0]            cfg_lane_mask,
  output logic                            rf_wr_valid,
  input  logic                            rf_wr_ready,
  output logic [IDX_W-1:0]                rf_wr_lane,
  output logic [REG_ADDR_W-1:0]           rf_wr_addr,
  output logic [LANE_WIDTH-1:0]           rf_wr_data,
  output logic                            load_done,
  output logic                            busy,
  output logic                            overrun_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LANES-1:0]    mask_q, mask_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;

  logic [NUM_LANES-1:0]    vld_q, vld_d;
  logic [NUM_LANES-1:0]    vld_kept;
  logic                    overrun_q, overrun_d;
  logic [LANE_WIDTH-1:0]   data_q [NUM_LANES];
  logic [LANE_WIDTH-1:0]   data_d [NUM_LANES];

  logic [IDX_W:0]          first_hit;
  logic [IDX_W:0]          next_hit;

  // Returns {found, index} of the lowest set bit of m at or above position start.
  function automatic logic [IDX_W:0] first_set(input logic [NUM_LANES-1:0] m, input int start);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i] && (i >= start)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign first_hit = first_set(mask_q, 0);
  assign next_hit  = first_set(mask_q, int'(ptr_q) + 1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with <= only so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dest_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dest_q  <= dest_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every target gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dest_d  = dest_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          mask_d  = cfg_lane_mask;
          dest_d  = cfg_dest_reg;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (mask_q == '0) begin
          state_d = DONE;
        end else if ((vld_q & mask_q) == mask_q) begin
          state_d = WRITE;
          ptr_d   = first_hit[IDX_W-1:0];
        end
      end
      WRITE: begin
        // Advance to the next masked lane in the accepting cycle so writes stream without bubbles.
        if (rf_wr_ready) begin
          if (next_hit[IDX_W]) ptr_d = next_hit[IDX_W-1:0];
          else                 state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    rf_wr_valid = (state_q == WRITE);
    load_done   = (state_q == DONE);
  end

  // Data is read live from the capture array so a late overwrite of a pending lane is delivered.
  assign rf_wr_lane  = ptr_q;
  assign rf_wr_addr  = dest_q;
  assign rf_wr_data  = data_q[ptr_q];
  assign overrun_err = overrun_q;

  // ---------------------------------------------------------------------------
  // Result capture: runs in every state
  // ---------------------------------------------------------------------------
  always_comb begin
    // Clearing the finished lanes happens before the set, so a strobe in DONE re-arms its lane.
    vld_kept  = (state_q == DONE) ? (vld_q & ~mask_q) : vld_q;
    vld_d     = vld_kept | lane_result_valid;
    overrun_d = overrun_q | (|(lane_result_valid & vld_kept));
    for (int i = 0; i < NUM_LANES; i++) begin
      data_d[i] = lane_result_valid[i] ? lane_result[i*LANE_WIDTH +: LANE_WIDTH] : data_q[i];
    end
  end

  // NOTE: the capture array is flop-based and is reset because rf_wr_data must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      vld_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) data_q[i] <= '0;
    end else begin
      vld_q     <= vld_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_LANES; i++) data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_simd_result_loader.sv
// Directed bench for simd_result_loader: each task drives one scenario and checks outputs
// 1 time unit after the rising edge against hand-computed values.
module tb_simd_result_loader;

  localparam int NUM_LANES  = 32;
  localparam int LANE_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int IDX_W      = 5;

  logic                            clk = 1'b0;
  logic                            reset_poweron;
  logic [NUM_LANES-1:0]            lane_result_valid;
  logic [NUM_LANES*LANE_WIDTH-1:0] lane_result;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [REG_ADDR_W-1:0]           cfg_dest_reg;
  logic [NUM_LANES-1:0]            cfg_lane_mask;
  logic                            rf_wr_valid;
  logic                            rf_wr_ready;
  logic [IDX_W-1:0]                rf_wr_lane;
  logic [REG_ADDR_W-1:0]           rf_wr_addr;
  logic [LANE_WIDTH-1:0]           rf_wr_data;
  logic                            load_done;
  logic                            busy;
  logic                            overrun_err;

  int total = 0;
  int bad   = 0;

  simd_result_loader #(
    .NUM_LANES (NUM_LANES),
    .LANE_WIDTH(LANE_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk              (clk),
    .reset_poweron    (reset_poweron),
    .lane_result_valid(lane_result_valid),
    .lane_result      (lane_result),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_dest_reg     (cfg_dest_reg),
    .cfg_lane_mask    (cfg_lane_mask),
    .rf_wr_valid      (rf_wr_valid),
    .rf_wr_ready      (rf_wr_ready),
    .rf_wr_lane       (rf_wr_lane),
    .rf_wr_addr       (rf_wr_addr),
    .rf_wr_data       (rf_wr_data),
    .load_done        (load_done),
    .busy             (busy),
    .overrun_err      (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_lane(input int lane, input logic [LANE_WIDTH-1:0] value);
    lane_result_valid[lane] = 1'b1;
    lane_result[lane*LANE_WIDTH +: LANE_WIDTH] = value;
  endtask

  task automatic clear_strobes();
    lane_result_valid = '0;
  endtask

  // Presents a request for one cycle from IDLE; on return the DUT is in COLLECT.
  task automatic start_load(input logic [NUM_LANES-1:0] mask, input logic [REG_ADDR_W-1:0] dest);
    cfg_valid     = 1'b1;
    cfg_lane_mask = mask;
    cfg_dest_reg  = dest;
    tick();
    cfg_valid     = 1'b0;
  endtask

  task automatic test_reset();
    reset_poweron     = 1'b1;
    lane_result_valid = '0;
    lane_result       = '0;
    cfg_valid         = 1'b0;
    cfg_dest_reg      = '0;
    cfg_lane_mask     = '0;
    rf_wr_ready       = 1'b0;
    tick();
    tick();
    total++;
    if ({cfg_ready, rf_wr_valid, load_done, busy, overrun_err} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got rdy/val/done/busy/ovr=%b required=10000",
               {cfg_ready, rf_wr_valid, load_done, busy, overrun_err});
    end
    total++;
    if ({rf_wr_lane, rf_wr_addr, rf_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_wr lane=%0d addr=%0d data=%h required all zero", rf_wr_lane, rf_wr_addr, rf_wr_data);
    end
    total++;
    if (dut.vld_q !== '0) begin
      bad++;
      $display("FAIL reset_vld got=%h required=0", dut.vld_q);
    end
    reset_poweron = 1'b0;
    tick();
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle cfg_ready=%b busy=%b required 1/0", cfg_ready, busy);
    end
  endtask

  task automatic test_full_mask();
    for (int i = 0; i < NUM_LANES; i++) strobe_lane(i, LANE_WIDTH'(100 + i));
    tick();
    clear_strobes();
    rf_wr_ready = 1'b1;
    start_load('1, 5'd7);
    total++;
    if (rf_wr_valid !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_collect valid=%b busy=%b cfg_ready=%b required 0/1/0", rf_wr_valid, busy, cfg_ready);
    end
    tick();
    for (int c = 0; c < NUM_LANES; c++) begin
      total++;
      if ({rf_wr_valid, load_done, rf_wr_lane, rf_wr_addr, rf_wr_data} !==
          {1'b1, 1'b0, IDX_W'(c), 5'd7, LANE_WIDTH'(100 + c)}) begin
        bad++;
        $display("FAIL full_write%0d valid=%b done=%b lane=%0d addr=%0d data=%0d required 1/0/%0d/7/%0d",
                 c, rf_wr_valid, load_done, rf_wr_lane, rf_wr_addr, rf_wr_data, c, 100 + c);
      end
      tick();
    end
    total++;
    if (load_done !== 1'b1 || rf_wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_done load_done=%b valid=%b required 1/0", load_done, rf_wr_valid);
    end
    tick();
    total++;
    if (load_done !== 1'b0 || cfg_ready !== 1'b1 || dut.vld_q !== '0) begin
      bad++;
      $display("FAIL full_after done=%b cfg_ready=%b vld=%h required 0/1/0", load_done, cfg_ready, dut.vld_q);
    end
  endtask

  task automatic test_sparse_backpressure();
    strobe_lane(0, 32'h11);
    strobe_lane(1, 32'h22);
    strobe_lane(2, 32'h33);
    tick();
    clear_strobes();
    rf_wr_ready = 1'b0;
    start_load(32'h5, 5'd3);
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd0, 5'd3, 32'h11}) begin
        bad++;
        $display("FAIL sparse_lane0_%0d valid=%b lane=%0d addr=%0d data=%h required 1/0/3/11",
                 k, rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data);
      end
      if (k == 0) tick();
    end
    rf_wr_ready = 1'b1;
    tick();
    rf_wr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd2, 5'd3, 32'h33}) begin
        bad++;
        $display("FAIL sparse_lane2_%0d valid=%b lane=%0d addr=%0d data=%h required 1/2/3/33",
                 k, rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data);
      end
      if (k == 0) tick();
    end
    rf_wr_ready = 1'b1;
    tick();
    total++;
    if (load_done !== 1'b1 || rf_wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL sparse_done load_done=%b valid=%b required 1/0", load_done, rf_wr_valid);
    end
    tick();
    total++;
    if (dut.vld_q !== 32'h2 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL sparse_retain vld=%h done=%b required 00000002/0", dut.vld_q, load_done);
    end
  endtask

  task automatic test_empty_mask();
    start_load('0, 5'd2);
    total++;
    if (load_done !== 1'b0 || rf_wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_collect done=%b valid=%b required 0/0", load_done, rf_wr_valid);
    end
    tick();
    total++;
    if (load_done !== 1'b1 || rf_wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_done done=%b valid=%b required 1/0", load_done, rf_wr_valid);
    end
    tick();
    total++;
    if (load_done !== 1'b0 || cfg_ready !== 1'b1 || dut.vld_q !== 32'h2) begin
      bad++;
      $display("FAIL empty_after done=%b cfg_ready=%b vld=%h required 0/1/00000002", load_done, cfg_ready, dut.vld_q);
    end
  endtask

  task automatic test_overrun();
    strobe_lane(3, 32'hA);
    tick();
    clear_strobes();
    total++;
    if (overrun_err !== 1'b0) begin
      bad++;
      $display("FAIL overrun_first got=%b required=0", overrun_err);
    end
    strobe_lane(3, 32'hB);
    tick();
    clear_strobes();
    total++;
    if (overrun_err !== 1'b1) begin
      bad++;
      $display("FAIL overrun_second got=%b required=1", overrun_err);
    end
    rf_wr_ready = 1'b1;
    start_load(32'h8, 5'd9);
    tick();
    total++;
    if ({rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd3, 5'd9, 32'hB}) begin
      bad++;
      $display("FAIL overrun_write valid=%b lane=%0d addr=%0d data=%h required 1/3/9/b",
               rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data);
    end
    tick();
    total++;
    if (load_done !== 1'b1) begin
      bad++;
      $display("FAIL overrun_done got=%b required=1", load_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 8; i++) strobe_lane(i, LANE_WIDTH'(32'h200 + i));
    tick();
    clear_strobes();
    rf_wr_ready = 1'b1;
    start_load(32'hFF, 5'd4);
    tick();
    for (int k = 0; k < 4; k++) tick();
    total++;
    if ({rf_wr_valid, rf_wr_lane, rf_wr_data, overrun_err} !== {1'b1, 5'd4, 32'h204, 1'b1}) begin
      bad++;
      $display("FAIL midrst_pre valid=%b lane=%0d data=%h ovr=%b required 1/4/204/1",
               rf_wr_valid, rf_wr_lane, rf_wr_data, overrun_err);
    end
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0;
    total++;
    if ({cfg_ready, rf_wr_valid, load_done, busy, overrun_err} !== 5'b10000) begin
      bad++;
      $display("FAIL midrst_ctrl got rdy/val/done/busy/ovr=%b required=10000",
               {cfg_ready, rf_wr_valid, load_done, busy, overrun_err});
    end
    total++;
    if (dut.vld_q !== '0 || {rf_wr_lane, rf_wr_addr, rf_wr_data} !== '0) begin
      bad++;
      $display("FAIL midrst_state vld=%h lane=%0d addr=%0d data=%h required all zero",
               dut.vld_q, rf_wr_lane, rf_wr_addr, rf_wr_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (load_done !== 1'b0 || rf_wr_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_quiet%0d done=%b valid=%b required 0/0", k, load_done, rf_wr_valid);
      end
    end
  endtask

  task automatic test_strobe_in_done();
    strobe_lane(5, 32'h55);
    tick();
    clear_strobes();
    rf_wr_ready = 1'b1;
    start_load(32'h20, 5'd1);
    tick();
    total++;
    if ({rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 5'd1, 32'h55}) begin
      bad++;
      $display("FAIL done_set_first valid=%b lane=%0d addr=%0d data=%h required 1/5/1/55",
               rf_wr_valid, rf_wr_lane, rf_wr_addr, rf_wr_data);
    end
    tick();
    strobe_lane(5, 32'h66);
    total++;
    if (load_done !== 1'b1) begin
      bad++;
      $display("FAIL done_set_pulse got=%b required=1", load_done);
    end
    tick();
    clear_strobes();
    total++;
    if (dut.vld_q !== 32'h20 || overrun_err !== 1'b0) begin
      bad++;
      $display("FAIL done_set_vld vld=%h ovr=%b required 00000020/0", dut.vld_q, overrun_err);
    end
    start_load(32'h20, 5'd1);
    tick();
    total++;
    if ({rf_wr_valid, rf_wr_lane, rf_wr_data} !== {1'b1, 5'd5, 32'h66}) begin
      bad++;
      $display("FAIL done_set_second valid=%b lane=%0d data=%h required 1/5/66",
               rf_wr_valid, rf_wr_lane, rf_wr_data);
    end
    tick();
    tick();
    total++;
    if (dut.vld_q !== '0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL done_set_end vld=%h cfg_ready=%b required 0/1", dut.vld_q, cfg_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_backpressure();
    test_empty_mask();
    test_overrun();
    test_reset_mid_write();
    test_strobe_in_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
